// File: rtl/codec_cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// codec_cfg_sequencer_if
// Bundles the runtime write request channel and the I2C byte-write controller
// handshake seen by the codec configuration sequencer.
//   wr_req   : runtime write request (level, held until wr_ack)
//   wr_data  : runtime payload {reg_addr[6:0], reg_data[8:0]}
//   wr_ack   : one-cycle pulse when a runtime write completes or is abandoned
//   i2c_data : {slave_addr, payload} presented to the I2C controller
//   go       : controller go; low resets/loads it, high runs the transfer
//   i2c_end  : controller end flag, high = transfer finished / idle
//   i2c_ack  : controller NACK-seen flag, 1 = at least one byte NACKed
// master = sequencer side, slave = player logic + I2C controller side.
// ---------------------------------------------------------------------------
interface codec_cfg_sequencer_if;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic [23:0] i2c_data;
  logic        go;
  logic        i2c_end;
  logic        i2c_ack;

  modport master (
    input  wr_req, wr_data, i2c_end, i2c_ack,
    output wr_ack, i2c_data, go
  );

  modport slave (
    output wr_req, wr_data, i2c_end, i2c_ack,
    input  wr_ack, i2c_data, go
  );
endinterface

// File: rtl/codec_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// codec_cfg_sequencer
// Walks the 8-entry codec power-up table through the I2C byte-write
// controller, then serves runtime register writes. NACKed transfers are
// retried; a transfer whose end flag never arrives times out and counts as a
// failed attempt.
// Ports:
//   clk_i       : system clock, rising edge
//   rst_i       : asynchronous active-high reset
//   start_i     : one-cycle pulse, rerun the init table (DONE/FAIL only)
//   bus         : write-request channel + I2C controller handshake
//   busy_o      : high in every state except DONE and FAIL
//   done_o      : high in DONE (init complete, serving requests)
//   error_o     : sticky give-up flag, cleared by start_i or reset
//   reg_index_o : current init-table index
//
// state | meaning
// LOAD  | latch payload (init table or runtime) onto i2c_data, go low
// ARM   | hold go low for ARM_CYCLES with data stable
// XFER  | go high, wait for end flag or timeout
// CHECK | go low, judge attempt, retry / advance / give up
// NEXT  | advance init index or acknowledge runtime write
// DONE  | init complete, idle, accepts runtime writes and start
// FAIL  | init abandoned, only start (or reset) leaves
// ---------------------------------------------------------------------------
module codec_cfg_sequencer #(
  parameter logic [7:0] SLAVE_ADDR = 8'h34,
  parameter int         ARM_CYCLES = 2,
  parameter int         MAX_RETRY  = 3,
  parameter int         TIMEOUT    = 63
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  codec_cfg_sequencer_if.master        bus,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [2:0]                   reg_index_o
);

  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_LOAD, S_ARM, S_XFER, S_CHECK, S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t        state_q;
  logic [2:0]    reg_index_q;
  logic          go_q;
  logic [23:0]   i2c_data_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic          wr_ack_q;
  logic [RW-1:0] retry_q;
  logic          src_q;      // 0 = init table, 1 = runtime request
  logic [AW-1:0] arm_q;
  logic [TW-1:0] tmo_q;
  logic          ok_q;       // last attempt: end seen with no NACK
  logic [15:0]   payload_d;

  function automatic logic [15:0] init_payload(input logic [2:0] idx);
    case (idx)
      3'd0:    init_payload = 16'h1E00;  // reset
      3'd1:    init_payload = 16'h0C00;  // power on
      3'd2:    init_payload = 16'h0E02;  // I2S 16-bit
      3'd3:    init_payload = 16'h1000;  // 48 kHz normal
      3'd4:    init_payload = 16'h0812;  // DAC select
      3'd5:    init_payload = 16'h0A00;  // unmute
      3'd6:    init_payload = 16'h0579;  // HP volume both channels
      3'd7:    init_payload = 16'h1201;  // active
      default: init_payload = 16'h1E00;
    endcase
  endfunction

  always_comb begin
    payload_d = src_q ? bus.wr_data : init_payload(reg_index_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_LOAD;
      reg_index_q <= 3'd0;
      go_q        <= 1'b0;
      i2c_data_q  <= {SLAVE_ADDR, 16'h1E00};
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      retry_q     <= '0;
      src_q       <= 1'b0;
      arm_q       <= '0;
      tmo_q       <= '0;
      ok_q        <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          i2c_data_q <= {SLAVE_ADDR, payload_d};
          go_q       <= 1'b0;
          arm_q      <= AW'(ARM_CYCLES - 1);
          state_q    <= S_ARM;
        end
        S_ARM: begin
          if (arm_q == '0) begin
            go_q    <= 1'b1;
            tmo_q   <= TW'(TIMEOUT - 1);
            state_q <= S_XFER;
          end else begin
            arm_q <= arm_q - AW'(1);
          end
        end
        S_XFER: begin
          // ACK only means anything in the cycle END is high
          if (bus.i2c_end) begin
            ok_q    <= ~bus.i2c_ack;
            go_q    <= 1'b0;
            state_q <= S_CHECK;
          end else if (tmo_q == '0) begin
            ok_q    <= 1'b0;
            go_q    <= 1'b0;
            state_q <= S_CHECK;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
        end
        S_CHECK: begin
          go_q <= 1'b0;
          if (ok_q) begin
            retry_q <= '0;
            state_q <= S_NEXT;
          end else if (retry_q < RETRY_MAX) begin
            retry_q <= retry_q + RW'(1);
            state_q <= S_LOAD;
          end else begin
            retry_q <= '0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            if (src_q) begin
              wr_ack_q <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_FAIL;
            end
          end
        end
        S_NEXT: begin
          if (src_q) begin
            wr_ack_q <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_DONE;
          end else if (reg_index_q == 3'd7) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            reg_index_q <= reg_index_q + 3'd1;
            state_q     <= S_LOAD;
          end
        end
        S_DONE: begin
          go_q <= 1'b0;
          if (start_i) begin
            reg_index_q <= 3'd0;
            error_q     <= 1'b0;
            src_q       <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            state_q     <= S_LOAD;
          end else if (bus.wr_req && !wr_ack_q) begin
            // Skip the ack cycle itself: the requester only sees wr_ack in
            // that cycle and drops wr_req in the following one.
            src_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_FAIL: begin
          go_q <= 1'b0;
          if (start_i) begin
            reg_index_q <= 3'd0;
            error_q     <= 1'b0;
            src_q       <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        default: begin
          go_q    <= 1'b0;
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.i2c_data = i2c_data_q;
  assign bus.go       = go_q;
  assign bus.wr_ack   = wr_ack_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign reg_index_o  = reg_index_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_codec_cfg_sequencer
// Directed bench for codec_cfg_sequencer. A small I2C controller model
// finishes each transfer after 33 GO-high cycles, logs every transfer's
// I2C_DATA and can NACK a chosen payload a set number of times or hang END.
// ---------------------------------------------------------------------------
module tb_codec_cfg_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, error;
  logic [2:0] reg_index;

  codec_cfg_sequencer_if bus();

  always #5 clk = ~clk;

  codec_cfg_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .bus         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .reg_index_o (reg_index)
  );

  // ---------------- controller model ----------------
  int          cnt = 0;
  int          go_len = 0;
  int          last_go_len = 0;
  int          log_n = 0;
  int          glitch_n = 0;
  int          used_n = 0;
  int          seen_epoch = 0;
  int          nack_epoch = 0;
  int          nack_limit = 0;    // <0 = NACK forever
  logic [23:0] nack_data = 24'hFFFFFF;
  logic        nack_cur = 1'b0;
  logic        hang_end = 1'b0;
  logic [23:0] xlog [0:127];

  assign bus.i2c_end = bus.go && (cnt == 32) && !hang_end;
  // ACK is deliberately high outside the END cycle; it must be ignored there
  assign bus.i2c_ack = bus.go && (bus.i2c_end ? nack_cur : 1'b1);

  always @(posedge clk) begin : model
    int u;
    if (!bus.go) begin
      cnt    <= 0;
      go_len <= 0;
      if (go_len != 0) last_go_len <= go_len;
    end else begin
      if (cnt < 32) cnt <= cnt + 1;
      go_len <= go_len + 1;
      if (cnt == 0) begin
        xlog[log_n] <= bus.i2c_data;
        log_n       <= log_n + 1;
        u = (nack_epoch != seen_epoch) ? 0 : used_n;
        seen_epoch <= nack_epoch;
        if (bus.i2c_data == nack_data && (nack_limit < 0 || u < nack_limit)) begin
          nack_cur <= 1'b1;
          used_n   <= u + 1;
        end else begin
          nack_cur <= 1'b0;
          used_n   <= u;
        end
      end else if (bus.i2c_data != xlog[log_n-1]) begin
        glitch_n <= glitch_n + 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sel: 0 done, 1 not busy, 2 wr_ack, 3 go with log_n >= target
  task automatic wait_cond(input string tag, input int sel, input int budget,
                           input int target, output int cycles);
    bit hit;
    hit = 1'b0;
    cycles = 0;
    while (!hit && cycles < budget) begin
      @(negedge clk);
      cycles++;
      case (sel)
        0:       hit = done;
        1:       hit = !busy;
        2:       hit = bus.wr_ack;
        default: hit = bus.go && (log_n >= target);
      endcase
    end
    check({tag, "_reached"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [23:0] exp_tab [0:7];
  int cyc, base, acks;

  initial begin
    exp_tab = '{24'h341E00, 24'h340C00, 24'h340E02, 24'h341000,
                24'h340812, 24'h340A00, 24'h340579, 24'h341201};
    rst = 1'b1;
    start = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_data = 16'h0000;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_go",        {31'd0, bus.go},       32'd0);
    check("rst_i2c_data",  {8'd0, bus.i2c_data},  32'h341E00);
    check("rst_busy",      {31'd0, busy},         32'd1);
    check("rst_done",      {31'd0, done},         32'd0);
    check("rst_error",     {31'd0, error},        32'd0);
    check("rst_wr_ack",    {31'd0, bus.wr_ack},   32'd0);
    check("rst_reg_index", {29'd0, reg_index},    32'd0);

    // clean init run
    base = log_n;
    rst = 1'b0;
    wait_cond("init", 0, 1000, 0, cyc);
    check("init_cycles", cyc, 304);
    check("init_count", log_n - base, 8);
    for (int i = 0; i < 8; i++) check("init_entry", {8'd0, xlog[base+i]}, {8'd0, exp_tab[i]});
    check("init_error", {31'd0, error}, 32'd0);
    check("init_busy",  {31'd0, busy},  32'd0);

    // runtime write
    base = log_n;
    bus.wr_data = 16'h0560;
    bus.wr_req = 1'b1;
    wait_cond("wr", 2, 200, 0, cyc);
    check("wr_cycles", cyc, 39);
    check("wr_done",   {31'd0, done},  32'd1);
    check("wr_error",  {31'd0, error}, 32'd0);
    check("wr_count",  log_n - base, 1);
    check("wr_data",   {8'd0, xlog[base]}, 32'h340560);
    @(negedge clk);
    check("wr_ack_single", {31'd0, bus.wr_ack}, 32'd0);
    check("wr_idle_busy",  {31'd0, busy}, 32'd0);
    bus.wr_req = 1'b0;
    repeat (5) @(negedge clk);
    check("wr_no_repeat", log_n - base, 1);
    check("wr_still_done", {31'd0, done}, 32'd1);

    // runtime write with END held low -> timeouts and give-up
    base = log_n;
    hang_end = 1'b1;
    bus.wr_req = 1'b1;
    wait_cond("tmo", 2, 400, 0, cyc);
    check("tmo_cycles", cyc, 269);
    check("tmo_count", log_n - base, 4);
    for (int i = 0; i < 4; i++) check("tmo_entry", {8'd0, xlog[base+i]}, 32'h340560);
    check("tmo_go_len", last_go_len, 63);
    check("tmo_error",  {31'd0, error}, 32'd1);
    check("tmo_done",   {31'd0, done},  32'd1);
    bus.wr_req = 1'b0;
    hang_end = 1'b0;
    @(negedge clk);
    check("tmo_ack_single", {31'd0, bus.wr_ack}, 32'd0);

    // START and WR_REQ together in DONE: init first, then the write
    base = log_n;
    bus.wr_data = 16'h0533;
    bus.wr_req = 1'b1;
    pulse_start();
    check("both_error_clr", {31'd0, error}, 32'd0);
    check("both_busy",      {31'd0, busy},  32'd1);
    check("both_index",     {29'd0, reg_index}, 32'd0);
    wait_cond("both", 2, 800, 0, cyc);
    check("both_count", log_n - base, 9);
    check("both_first", {8'd0, xlog[base]},   32'h341E00);
    check("both_last",  {8'd0, xlog[base+7]}, 32'h341201);
    check("both_wr",    {8'd0, xlog[base+8]}, 32'h340533);
    check("both_done",  {31'd0, done}, 32'd1);
    bus.wr_req = 1'b0;
    @(negedge clk);

    // entry 3 NACKed twice, then accepted
    nack_data = 24'h341000;
    nack_limit = 2;
    nack_epoch++;
    base = log_n;
    pulse_start();
    wait_cond("nack3", 0, 1200, 0, cyc);
    check("nack3_cycles", cyc, 378);
    check("nack3_count", log_n - base, 10);
    for (int i = 3; i < 6; i++) check("nack3_retry", {8'd0, xlog[base+i]}, 32'h341000);
    check("nack3_next",  {8'd0, xlog[base+6]}, 32'h340812);
    check("nack3_last",  {8'd0, xlog[base+9]}, 32'h341201);
    check("nack3_error", {31'd0, error}, 32'd0);

    // entry 5 always NACKed -> FAIL
    nack_data = 24'h340A00;
    nack_limit = -1;
    nack_epoch++;
    base = log_n;
    pulse_start();
    wait_cond("fail", 1, 1200, 0, cyc);
    check("fail_done",  {31'd0, done},  32'd0);
    check("fail_error", {31'd0, error}, 32'd1);
    check("fail_index", {29'd0, reg_index}, 32'd5);
    check("fail_count", log_n - base, 9);
    check("fail_prev",  {8'd0, xlog[base+4]}, 32'h340812);
    for (int i = 5; i < 9; i++) check("fail_attempt", {8'd0, xlog[base+i]}, 32'h340A00);
    base = log_n;
    bus.wr_data = 16'h0560;
    bus.wr_req = 1'b1;
    acks = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.wr_ack) acks++;
    end
    check("fail_no_wr_ack", acks, 0);
    check("fail_no_xfer", log_n - base, 0);
    check("fail_stays", {30'd0, busy, done}, 32'd0);
    bus.wr_req = 1'b0;
    nack_limit = 0;
    nack_epoch++;
    base = log_n;
    pulse_start();
    check("restart_error", {31'd0, error}, 32'd0);
    check("restart_busy",  {31'd0, busy},  32'd1);
    check("restart_index", {29'd0, reg_index}, 32'd0);
    wait_cond("restart", 0, 1000, 0, cyc);
    check("restart_count", log_n - base, 8);
    check("restart_first", {8'd0, xlog[base]}, 32'h341E00);
    check("restart_error_end", {31'd0, error}, 32'd0);

    // reset during XFER of entry 4
    base = log_n;
    pulse_start();
    wait_cond("xfer4", 3, 400, base + 5, cyc);
    check("xfer4_data", {8'd0, xlog[base+4]}, 32'h340812);
    repeat (3) @(negedge clk);
    check("xfer4_go", {31'd0, bus.go}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstx_go",    {31'd0, bus.go}, 32'd0);
    check("rstx_index", {29'd0, reg_index}, 32'd0);
    check("rstx_data",  {8'd0, bus.i2c_data}, 32'h341E00);
    @(negedge clk);
    base = log_n;
    rst = 1'b0;
    wait_cond("rstx", 0, 1000, 0, cyc);
    check("rstx_count", log_n - base, 8);
    check("rstx_first", {8'd0, xlog[base]}, 32'h341E00);
    check("rstx_error", {31'd0, error}, 32'd0);

    check("data_stable_while_go", glitch_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
